// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared encodings for the RV32I hazard unit:
//   optype_e : op class of an instruction as seen by hazard tracking
//   fwd_e    : operand source select driven to the EX-stage muxes
//   REG_AW_DEFAULT : default register-address width
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    OPT_NONE  = 2'd0,
    OPT_ALU   = 2'd1,
    OPT_LOAD  = 2'd2,
    OPT_STORE = 2'd3
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF       = 2'd0,
    FWD_EX_ALU   = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_e;

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg
// One tracked pipeline slot {rd, rs2, optype} for the hazard unit.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bubble              : load an empty slot instead of the incoming one
//   rd_d, rs2_d, optype_d : incoming slot contents
//   rd_q, rs2_q, optype_q : registered slot contents
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [1:0]        optype_d,
  output logic [REG_AW-1:0] rd_q,
  output logic [REG_AW-1:0] rs2_q,
  output logic [1:0]        optype_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rs2_q    <= '0;
      optype_q <= OPT_NONE;
    end else if (bubble) begin
      rd_q     <= '0;
      rs2_q    <= '0;
      optype_q <= OPT_NONE;
    end else begin
      rd_q     <= rd_d;
      rs2_q    <= rs2_d;
      optype_q <= optype_d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard detection and forwarding control for the 5-stage RV32I pipeline.
// Tracks {rd, rs2, optype} of the instructions in EX (_p0), MEM (_p1) and
// WB (_p2) and derives, combinationally from the ID fields plus that state:
//   forward_ctrl_A/B : rs1/rs2 operand source (fwd_e encoding)
//   forward_ctrl_ls  : store in MEM takes its data from the WB load result
//   PC_EN_IF, reg_FD_EN : held low for one cycle on a load-use stall
//   reg_DE_flush     : bubble into ID/EX during a stall
//   reg_FD_flush     : squash IF/ID after a taken branch (not while stalling)
//   stall_cnt, flush_cnt : event counters, only built when HAZARD_STATS_EN
//                          is defined; otherwise constant 0
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic              Branch_ID,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  logic [REG_AW-1:0] rd_p0, rd_p1, rd_p2;
  logic [REG_AW-1:0] rs2_p0, rs2_p1;
  logic [1:0]        opt_p0, opt_p1, opt_p2;
  logic              stall;

  // Only ALU and LOAD results ever land in the regfile; x0 is never a source.
  function automatic logic reg_match(input logic [REG_AW-1:0] rs,
                                     input logic              rs_use,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [1:0]        opt);
    return rs_use && (rs == rd) && (rd != '0) &&
           ((opt == OPT_ALU) || (opt == OPT_LOAD));
  endfunction

  // A load still in EX has no data yet, and it shadows any older MEM writer
  // of the same register, so that case selects the regfile (the stall or
  // the store-data path takes care of it).
  function automatic logic [1:0] fwd_sel(input logic       m_ex,
                                         input logic       m_mem,
                                         input logic [1:0] o_ex,
                                         input logic [1:0] o_mem);
    if (m_ex)       return (o_ex == OPT_ALU) ? FWD_EX_ALU : FWD_RF;
    else if (m_mem) return (o_mem == OPT_ALU) ? FWD_MEM_ALU : FWD_MEM_LOAD;
    else            return FWD_RF;
  endfunction

  logic m1_ex, m2_ex, m1_mem, m2_mem;

  assign m1_ex  = reg_match(rs1_ID, rs1use_ID, rd_p0, opt_p0);
  assign m2_ex  = reg_match(rs2_ID, rs2use_ID, rd_p0, opt_p0);
  assign m1_mem = reg_match(rs1_ID, rs1use_ID, rd_p1, opt_p1);
  assign m2_mem = reg_match(rs2_ID, rs2use_ID, rd_p1, opt_p1);

  // A store whose only dependency on the EX load is its data operand does
  // not stall: the data is picked up later from WB via forward_ctrl_ls.
  assign stall = (opt_p0 == OPT_LOAD) &&
                 (m1_ex || (m2_ex && (hazard_optype_ID != OPT_STORE)));

  assign forward_ctrl_A  = fwd_sel(m1_ex, m1_mem, opt_p0, opt_p1);
  assign forward_ctrl_B  = fwd_sel(m2_ex, m2_mem, opt_p0, opt_p1);
  assign forward_ctrl_ls = (opt_p1 == OPT_STORE) && (opt_p2 == OPT_LOAD) &&
                           (rd_p2 != '0) && (rd_p2 == rs2_p1);

  assign PC_EN_IF     = !stall;
  assign reg_FD_EN    = !stall;
  assign reg_DE_flush = stall;
  // Branch decided on stale operands while stalling; it re-resolves next cycle.
  assign reg_FD_flush = Branch_ID && !stall;

  // ID -> EX boundary (bubble on stall)
  hazard_stage_reg #(.REG_AW(REG_AW)) u_slot_ex (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble   (stall),
    .rd_d     (rd_ID),
    .rs2_d    (rs2_ID),
    .optype_d (hazard_optype_ID),
    .rd_q     (rd_p0),
    .rs2_q    (rs2_p0),
    .optype_q (opt_p0)
  );

  // EX -> MEM boundary
  hazard_stage_reg #(.REG_AW(REG_AW)) u_slot_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble   (1'b0),
    .rd_d     (rd_p0),
    .rs2_d    (rs2_p0),
    .optype_d (opt_p0),
    .rd_q     (rd_p1),
    .rs2_q    (rs2_p1),
    .optype_q (opt_p1)
  );

  // MEM -> WB boundary (rs2 is not needed past MEM)
  hazard_stage_reg #(.REG_AW(REG_AW)) u_slot_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble   (1'b0),
    .rd_d     (rd_p1),
    .rs2_d    (rs2_p1),
    .optype_d (opt_p1),
    .rd_q     (rd_p2),
    .rs2_q    (),
    .optype_q (opt_p2)
  );

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      if (reg_FD_flush) flush_cnt_q <= flush_cnt_q + STAT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
